// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and FIFO word packing helpers for the write-side arbiter
//   and the read-side demux. A FIFO word is {src_id, last, data}.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANTED
    } arb_state_t;

    // Parameterised pack/unpack helpers; call as fifo_word#(IW, DW)::pack(...)
    virtual class fifo_word #(int ID_W = 2, int DATA_W = 32);
        static function logic [ID_W+DATA_W:0] pack(input logic [ID_W-1:0]   id,
                                                   input logic              last,
                                                   input logic [DATA_W-1:0] data);
            return {id, last, data};
        endfunction

        static function logic [ID_W-1:0] src_id(input logic [ID_W+DATA_W:0] w);
            return w[ID_W+DATA_W -: ID_W];
        endfunction

        static function logic is_last(input logic [ID_W+DATA_W:0] w);
            return w[DATA_W];
        endfunction

        static function logic [DATA_W-1:0] payload(input logic [ID_W+DATA_W:0] w);
            return w[DATA_W-1:0];
        endfunction
    endclass

endpackage

// File: rtl/fifo_write_arbiter_picker.sv
// rr_priority_picker
//   Combinational round-robin picker. Searches req upward (mod N) starting
//   at last_grant+1 and returns the first set index.
//   req        : request vector
//   last_grant : most recently granted index
//   winner     : selected index (valid when found)
//   found      : at least one request set
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] winner,
    output logic          found
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] rot;
    logic [IW-1:0]  start;
    logic [IW-1:0]  offset;

    always_comb begin
        // N is a power of two, so IW-bit arithmetic wraps mod N for free.
        start  = last_grant + 1'b1;
        dbl    = {req, req};
        rot    = dbl >> start;
        offset = '0;
        found  = 1'b0;
        // Walk downward so the lowest set bit (closest to start) wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = IW'(i);
                found  = 1'b1;
            end
        end
        winner = start + offset;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin, packet-locked arbiter sharing one async_fifo write port
//   among NUM_REQUESTERS sources. Write-clock domain only.
//   clk, reset          : write clock, synchronous active-high reset
//   req_valid/last/data : per-source beat stream (data i at [i*DW +: DW])
//   req_ready           : beat accepted this cycle (one-hot or zero)
//   fifo_write_enable   : FIFO write strobe, never asserted while fifo_full
//   fifo_write_data     : {src_id, last, data}
//   fifo_full           : FIFO full, sampled combinationally
//   grant_active/id     : current packet owner
//   burst_error         : sticky, a grant ran past MAX_BURST beats
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQUESTERS = 4,
    parameter  int DATA_WIDTH     = 32,
    parameter  int MAX_BURST      = 16,
    localparam int ID_WIDTH       = $clog2(NUM_REQUESTERS),
    localparam int FIFO_WIDTH     = ID_WIDTH + 1 + DATA_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQUESTERS-1:0]          req_valid,
    input  logic [NUM_REQUESTERS-1:0]          req_last,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQUESTERS-1:0]          req_ready,
    output logic                               fifo_write_enable,
    output logic [FIFO_WIDTH-1:0]              fifo_write_data,
    input  logic                               fifo_full,
    output logic                               grant_active,
    output logic [ID_WIDTH-1:0]                grant_id,
    output logic                               burst_error
);

    localparam int                CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_t          state_q, state_d;
    logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    beat_count_q, beat_count_d;
    logic                burst_error_q, burst_error_d;

    logic [ID_WIDTH-1:0]   pick_id;
    logic                  pick_found;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  accept;

    rr_priority_picker #(
        .N  (NUM_REQUESTERS),
        .IW (ID_WIDTH)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .winner     (pick_id),
        .found      (pick_found)
    );

    always_comb begin
        state_d           = state_q;
        grant_id_d        = grant_id_q;
        last_grant_d      = last_grant_q;
        beat_count_d      = beat_count_q;
        burst_error_d     = burst_error_q;
        accept            = 1'b0;
        req_ready         = '0;
        fifo_write_enable = 1'b0;

        // Only the owner's lane reaches the outputs; non-owner valids feed
        // the picker, whose result is only registered.
        sel_valid = req_valid[grant_id_q];
        sel_last  = req_last[grant_id_q];
        sel_data  = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_id_d   = pick_id;
                    last_grant_d = pick_id;
                    beat_count_d = '0;
                    state_d      = ARB_GRANTED;
                end
            end
            ARB_GRANTED: begin
                // Reset gating keeps the reset cycle write-free.
                accept = sel_valid && !fifo_full && !reset;
                if (accept) begin
                    req_ready[grant_id_q] = 1'b1;
                    fifo_write_enable     = 1'b1;
                    if (beat_count_q != CNT_MAX) begin
                        beat_count_d = beat_count_q + 1'b1;
                    end else begin
                        // MAX_BURST beats already taken: this one is beyond
                        // the budget whether or not it closes the packet.
                        burst_error_d = 1'b1;
                    end
                    if (sel_last) begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        fifo_write_data = fifo_word#(ID_WIDTH, DATA_WIDTH)::pack(grant_id_q, sel_last, sel_data);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            grant_id_q    <= '0;
            last_grant_q  <= ID_WIDTH'(NUM_REQUESTERS - 1);
            beat_count_q  <= '0;
            burst_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            beat_count_q  <= beat_count_d;
            burst_error_q <= burst_error_d;
        end
    end

    assign grant_active = (state_q == ARB_GRANTED);
    assign grant_id     = grant_id_q;
    assign burst_error  = burst_error_q;

endmodule
